demultiplexer: RTL and testbench



---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_decoder.sv | 24 ++
 rtl/demultiplexer.sv | 56 +++++
 tb/tb_demultiplexer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared defaults and helpers for the 1-to-N demultiplexer
package demux_pkg;

    // Default selector width: 2 bits selects one of four outputs
    localparam int DEFAULT_SEL_W  = 2;
    // Default data width of the input and of each output slice
    localparam int DEFAULT_DATA_W = 1;

    // Number of output slices addressed by a selector of the given width
    function automatic int demux_num_outputs(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/demux_decoder.sv
// rtl/demux_decoder.sv - SEL_W-to-N one-hot decoder with unknown selectors decoding to all zeros
module demux_decoder
    import demux_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic [SEL_W-1:0]                    i_sel,
    output logic [demux_num_outputs(SEL_W)-1:0] o_onehot
);

    localparam int N = demux_num_outputs(SEL_W);

    // Compare the selector against every slice index. An unknown selector makes
    // the if-condition false, so every bit falls back to the zero default.
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demultiplexer.sv
// rtl/demultiplexer.sv - 1-to-N demultiplexer, optional output register via DEMULTIPLEXER_REG_OUT_EN
module demultiplexer
    import demux_pkg::*;
#(
    parameter int SEL_W  = DEFAULT_SEL_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_W-1:0]                          I,
    input  logic [SEL_W-1:0]                           S,
    output logic [demux_num_outputs(SEL_W)*DATA_W-1:0] Y
);

    localparam int N = demux_num_outputs(SEL_W);

    logic [N-1:0]        w_onehot;
    logic [N*DATA_W-1:0] w_y;

    demux_decoder #(
        .SEL_W (SEL_W)
    ) u_decoder (
        .i_sel    (S),
        .o_onehot (w_onehot)
    );

    // Gate the data into each slice with its one-hot enable; unselected slices stay zero
    always_comb begin
        w_y = '0;
        for (int k = 0; k < N; k++) begin
            w_y[k*DATA_W +: DATA_W] = I & {DATA_W{w_onehot[k]}};
        end
    end

`ifdef DEMULTIPLEXER_REG_OUT_EN
    logic [N*DATA_W-1:0] r_y;

    // Output register: captures the routed data each edge, cleared at once by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_y;
        end
    end

    assign Y = r_y;
`else
    // Clock and reset stay on the port list for drop-in compatibility but do nothing here
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign Y = w_y;
`endif

endmodule

// File: tb/tb_demultiplexer.sv
// tb/tb_demultiplexer.sv - scoreboard bench for demultiplexer in default and 8-bit/3-bit configurations
module tb_demultiplexer;

`ifdef DEMULTIPLEXER_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_d = 1'b0;
    logic [1:0]  s_d = 2'b00;
    logic [3:0]  y4;
    logic [7:0]  iw  = 8'h00;
    logic [2:0]  sw  = 3'd0;
    logic [63:0] y64;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [3:0]  e4;
        logic [63:0] e64;
    } exp_t;

    exp_t q[$];

    demultiplexer dut (
        .clk (clk),
        .rst (rst),
        .I   (i_d),
        .S   (s_d),
        .Y   (y4)
    );

    demultiplexer #(
        .SEL_W  (3),
        .DATA_W (8)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .I   (iw),
        .S   (sw),
        .Y   (y64)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and queue what both DUTs should show after the next rising edge
    task automatic vec(input string nm, input logic i, input logic [1:0] s,
                       input logic [7:0] wi, input logic [2:0] ws,
                       input logic [3:0] e4, input logic [63:0] e64);
        exp_t e;
        @(negedge clk);
        i_d = i;
        s_d = s;
        iw  = wi;
        sw  = ws;
        e.name = nm;
        e.e4   = e4;
        e.e64  = e64;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && q.size() > 0; c++) @(posedge clk);
        #2;
        check("queue_drained", 64'(q.size()), 64'd0);
    endtask

    // Monitor: compare outputs just after each rising edge against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, "_y4"}, 64'(y4), 64'(e.e4));
                check({e.name, "_y64"}, y64, e.e64);
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        logic [1:0] sx;
        logic [3:0] ex;
        i_d = 1'b1;
        s_d = 2'b01;
        #1 rst = 1'b1;
        #2;
        check("reset_no_clock", 64'(y4), REG ? 64'h0 : 64'h2);
        @(posedge clk);
        #1;
        check("reset_held", 64'(y4), REG ? 64'h0 : 64'h2);
        @(negedge clk);
        rst = 1'b0;

        vec("idle",     1'b0, 2'b00, 8'h00, 3'd0, 4'b0000, 64'h0);
        vec("route_s0", 1'b1, 2'b00, 8'h3C, 3'd0, 4'b0001, 64'h0000_0000_0000_003C);
        vec("route_s1", 1'b1, 2'b01, 8'h00, 3'd0, 4'b0010, 64'h0);
        vec("route_s2", 1'b1, 2'b10, 8'h81, 3'd2, 4'b0100, 64'h0000_0000_0081_0000);
        vec("route_s3", 1'b1, 2'b11, 8'hFF, 3'd7, 4'b1000, 64'hFF00_0000_0000_0000);
        vec("toggle_1", 1'b1, 2'b10, 8'hA5, 3'd5, 4'b0100, 64'h0000_A500_0000_0000);
        vec("toggle_0", 1'b0, 2'b10, 8'h00, 3'd5, 4'b0000, 64'h0);
        vec("toggle_1b",1'b1, 2'b10, 8'hA5, 3'd5, 4'b0100, 64'h0000_A500_0000_0000);

        sx = 2'bx1;
        ex = $isunknown(sx) ? 4'b0000 : (4'b0001 << sx);
        vec("x_select", 1'b1, sx, 8'h5A, 3'd1, ex, 64'h0000_0000_0000_5A00);

        vec("pre_latency", 1'b1, 2'b01, 8'h00, 3'd0, 4'b0010, 64'h0);
        @(posedge clk);
        #2;
        @(negedge clk);
        s_d = 2'b11;
        #1;
        check("latency_before_edge", 64'(y4), REG ? 64'h2 : 64'h8);
        begin
            exp_t e;
            e.name = "latency_after_edge";
            e.e4   = 4'b1000;
            e.e64  = 64'h0;
            q.push_back(e);
        end
        @(posedge clk);
        #2;

        vec("pre_reset", 1'b1, 2'b01, 8'hA5, 3'd5, 4'b0010, 64'h0000_A500_0000_0000);
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_reset_y4", 64'(y4), REG ? 64'h0 : 64'h2);
        check("midrun_reset_y64", y64, REG ? 64'h0 : 64'h0000_A500_0000_0000);
        @(posedge clk);
        #1;
        check("midrun_reset_held", 64'(y4), REG ? 64'h0 : 64'h2);
        @(negedge clk);
        rst = 1'b0;
        i_d = 1'b1;
        s_d = 2'b11;
        iw  = 8'h3C;
        sw  = 3'd6;
        begin
            exp_t e;
            e.name = "after_reset_capture";
            e.e4   = 4'b1000;
            e.e64  = 64'h003C_0000_0000_0000;
            q.push_back(e);
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
